// File: rtl/mcdf_arbiter.sv
// Packet-level arbiter for the three MCDF slave channels: picks one eligible channel by
// priority (round-robin on ties), drains one packet of the configured length to the formatter.
module mcdf_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int PRIO_WIDTH = 2,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv0_req_i,
  input  logic                  slv1_req_i,
  input  logic                  slv2_req_i,
  input  logic                  slv0_en_i,
  input  logic                  slv1_en_i,
  input  logic                  slv2_en_i,
  input  logic [PRIO_WIDTH-1:0] slv0_prio_i,
  input  logic [PRIO_WIDTH-1:0] slv1_prio_i,
  input  logic [PRIO_WIDTH-1:0] slv2_prio_i,
  input  logic [LEN_WIDTH-1:0]  slv0_pkglen_i,
  input  logic [LEN_WIDTH-1:0]  slv1_pkglen_i,
  input  logic [LEN_WIDTH-1:0]  slv2_pkglen_i,
  input  logic [DATA_WIDTH-1:0] slv0_data_i,
  input  logic [DATA_WIDTH-1:0] slv1_data_i,
  input  logic [DATA_WIDTH-1:0] slv2_data_i,
  output logic                  slv0_ack_o,
  output logic                  slv1_ack_o,
  output logic                  slv2_ack_o,
  input  logic                  f_a_rdy_i,
  output logic                  a_val_o,
  output logic [DATA_WIDTH-1:0] a_data_o,
  output logic [1:0]            a_id_o,
  output logic [5:0]            a_len_o,
  output logic                  a_sop_o,
  output logic                  a_eop_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            id_q, id_d;
  logic [5:0]            len_q, len_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [1:0]            rr_q, rr_d;
  logic                  a_val_q, a_val_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [1:0]            a_id_q, a_id_d;
  logic [5:0]            a_len_q, a_len_d;
  logic                  a_sop_q, a_sop_d;
  logic                  a_eop_q, a_eop_d;

  // Four-entry views so a 2-bit channel index never falls outside an array; entry 3 is inert.
  logic [3:0]            req;
  logic [3:0]            elig;
  logic [PRIO_WIDTH-1:0] prio   [4];
  logic [LEN_WIDTH-1:0]  pkglen [4];
  logic [DATA_WIDTH-1:0] data   [4];

  assign req       = {1'b0, slv2_req_i, slv1_req_i, slv0_req_i};
  assign elig      = req & {1'b0, slv2_en_i, slv1_en_i, slv0_en_i};
  assign prio[0]   = slv0_prio_i;
  assign prio[1]   = slv1_prio_i;
  assign prio[2]   = slv2_prio_i;
  assign prio[3]   = '0;
  assign pkglen[0] = slv0_pkglen_i;
  assign pkglen[1] = slv1_pkglen_i;
  assign pkglen[2] = slv2_pkglen_i;
  assign pkglen[3] = '0;
  assign data[0]   = slv0_data_i;
  assign data[1]   = slv1_data_i;
  assign data[2]   = slv2_data_i;
  assign data[3]   = '0;

  function automatic logic [5:0] decode_len(input logic [LEN_WIDTH-1:0] code);
    if (code == LEN_WIDTH'(0))      return 6'd4;
    else if (code == LEN_WIDTH'(1)) return 6'd8;
    else if (code == LEN_WIDTH'(2)) return 6'd16;
    else                            return 6'd32;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] ptr, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, ptr} + {1'b0, k} + 3'd1;
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan channels in round-robin order; a strictly lower priority value replaces the
  // current pick, so among equal priorities the first one in scan order wins.
  logic                  found;
  logic [1:0]            win;
  logic [1:0]            idx;
  logic [PRIO_WIDTH-1:0] best;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    best  = '1;
    for (int k = 0; k < 3; k++) begin
      idx = rr_next(rr_q, 2'(k));
      if (elig[idx] && (!found || (prio[idx] < best))) begin
        found = 1'b1;
        win   = idx;
        best  = prio[idx];
      end
    end
  end

  logic       beat;
  logic       last;
  logic [3:0] ack;

  assign last = ({1'b0, cnt_q} == (len_q - 6'd1));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    beat    = 1'b0;
    ack     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = win;
          len_d   = decode_len(pkglen[win]);
          cnt_d   = 5'd0;
          rr_d    = win;
          state_d = XFER;
        end
      end
      XFER: begin
        beat     = req[id_q] & f_a_rdy_i;
        ack[id_q] = beat;
        if (beat) begin
          cnt_d = cnt_q + 5'd1;
          if (last) state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output framing is registered; id/len are refreshed only on beats so they hold between packets.
  always_comb begin
    a_val_d  = beat;
    a_data_d = beat ? data[id_q] : a_data_q;
    a_id_d   = beat ? id_q : a_id_q;
    a_len_d  = beat ? len_q : a_len_q;
    a_sop_d  = beat & (cnt_q == 5'd0);
    a_eop_d  = beat & last;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= 2'd0;
      len_q    <= 6'd0;
      cnt_q    <= 5'd0;
      rr_q     <= 2'd2;
      a_val_q  <= 1'b0;
      a_data_q <= '0;
      a_id_q   <= 2'd0;
      a_len_q  <= 6'd0;
      a_sop_q  <= 1'b0;
      a_eop_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      a_val_q  <= a_val_d;
      a_data_q <= a_data_d;
      a_id_q   <= a_id_d;
      a_len_q  <= a_len_d;
      a_sop_q  <= a_sop_d;
      a_eop_q  <= a_eop_d;
    end
  end

  assign slv0_ack_o  = ack[0];
  assign slv1_ack_o  = ack[1];
  assign slv2_ack_o  = ack[2];
  assign a_val_o     = a_val_q;
  assign a_data_o    = a_data_q;
  assign a_id_o      = a_id_q;
  assign a_len_o     = a_len_q;
  assign a_sop_o     = a_sop_q;
  assign a_eop_o     = a_eop_q;
  assign dbg_state_o = state_q;

endmodule
